// File: rtl/cmd_queue.sv
// In-order command queue between the back-end Arbiter and the command generator.
// Each entry is tagged at enqueue with a row-hit bit from a 16-bank open-row table.
module cmd_queue #(
  parameter int DQ          = 16,
  parameter int IDX         = 6,
  parameter int RA          = 16,
  parameter int CA          = 10,
  parameter int DEPTH       = 8,
  parameter int AFULL_SLACK = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DQ-1:0]              data_i,
  input  logic [IDX-1:0]             idx_i,
  input  logic [RA-1:0]              row_i,
  input  logic [CA-1:0]              col_i,
  input  logic                       t_i,
  input  logic [1:0]                 ba_i,
  input  logic [1:0]                 bg_i,
  input  logic                       pre_all,
  output logic                       flag,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [DQ-1:0]              data_o,
  output logic [IDX-1:0]             idx_o,
  output logic [RA-1:0]              row_o,
  output logic [CA-1:0]              col_o,
  output logic                       t_o,
  output logic [1:0]                 ba_o,
  output logic [1:0]                 bg_o,
  output logic                       hit_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       err_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] FLAG_CNT  = CW'(DEPTH - AFULL_SLACK);
  localparam int NBANK = 16;

  typedef struct packed {
    logic [DQ-1:0]  data;
    logic [IDX-1:0] idx;
    logic [RA-1:0]  row;
    logic [CA-1:0]  col;
    logic           t;
    logic [1:0]     ba;
    logic [1:0]     bg;
    logic           hit;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count_next;
  logic            full;
  logic            pop;
  logic            push;
  logic            overflow;

  logic [3:0]      bank;
  logic [NBANK-1:0] open_valid;
  logic [RA-1:0]   open_row [NBANK];
  logic            hit_new;

  // ---------------------------------------------------------------------------
  // Handshake and occupancy
  // ---------------------------------------------------------------------------
  assign valid_o  = (count_o != '0);
  assign full     = (count_o == FULL_CNT);
  assign pop      = valid_o & ready_i;
  // A full queue can still accept when the head leaves in the same cycle.
  assign push     = wr_en & (~full | pop);
  assign overflow = wr_en & full & ~pop;

  always_comb begin
    count_next = count_o;
    case ({push, pop})
      2'b10:   count_next = count_o + CW'(1);
      2'b01:   count_next = count_o - CW'(1);
      default: count_next = count_o;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Row-hit lookup; pre_all wins over any stale open row in the same cycle
  // ---------------------------------------------------------------------------
  assign bank    = {bg_i, ba_i};
  assign hit_new = ~pre_all & open_valid[bank] & (open_row[bank] == row_i);

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = data_i;
    wr_entry.idx  = idx_i;
    wr_entry.row  = row_i;
    wr_entry.col  = col_i;
    wr_entry.t    = t_i;
    wr_entry.ba   = ba_i;
    wr_entry.bg   = bg_i;
    wr_entry.hit  = hit_new;
  end

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_o <= '0;
      flag    <= 1'b1;
      err_o   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count_o <= count_next;
      flag    <= (count_next <= FLAG_CNT);
      if (overflow) err_o <= 1'b1;
    end
  end

  // The later per-bank set overrides the blanket clear for the pushed bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      open_valid <= '0;
    end else begin
      if (pre_all) open_valid <= '0;
      if (push)    open_valid[bank] <= 1'b1;
    end
  end

  // NOTE: storage arrays carry no reset; validity is owned by the pointers,
  // open_valid and count_o, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr]      <= wr_entry;
      open_row[bank] <= row_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Head presentation, zeroed whenever the queue is empty
  // ---------------------------------------------------------------------------
  assign head   = valid_o ? mem[rptr] : '0;
  assign data_o = head.data;
  assign idx_o  = head.idx;
  assign row_o  = head.row;
  assign col_o  = head.col;
  assign t_o    = head.t;
  assign ba_o   = head.ba;
  assign bg_o   = head.bg;
  assign hit_o  = head.hit;

endmodule

// File: tb/tb_cmd_queue.sv
// Directed self-checking bench for cmd_queue (DEPTH=8, AFULL_SLACK=2).
module tb_cmd_queue;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] data_i;
  logic [5:0]  idx_i;
  logic [15:0] row_i;
  logic [9:0]  col_i;
  logic        t_i;
  logic [1:0]  ba_i;
  logic [1:0]  bg_i;
  logic        pre_all;
  logic        flag;
  logic        valid_o;
  logic        ready_i;
  logic [15:0] data_o;
  logic [5:0]  idx_o;
  logic [15:0] row_o;
  logic [9:0]  col_o;
  logic        t_o;
  logic [1:0]  ba_o;
  logic [1:0]  bg_o;
  logic        hit_o;
  logic [3:0]  count_o;
  logic        err_o;

  int tests_run    = 0;
  int tests_failed = 0;

  cmd_queue dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .data_i(data_i), .idx_i(idx_i),
    .row_i(row_i), .col_i(col_i), .t_i(t_i), .ba_i(ba_i), .bg_i(bg_i),
    .pre_all(pre_all), .flag(flag), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .idx_o(idx_o), .row_o(row_o), .col_o(col_o), .t_o(t_o),
    .ba_o(ba_o), .bg_o(bg_o), .hit_o(hit_o), .count_o(count_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [1:0] g, input logic [1:0] a,
                         input logic [15:0] r, input logic [5:0] i,
                         input logic pa);
    wr_en   = 1'b1;
    bg_i    = g;
    ba_i    = a;
    row_i   = r;
    idx_i   = i;
    data_i  = {r[7:0], 2'b00, i};
    col_i   = {4'h0, i};
    t_i     = i[0];
    pre_all = pa;
    step();
    wr_en   = 1'b0;
    pre_all = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    tests_run++;
    if ({count_o, valid_o, flag, err_o} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_state got count=%0d valid=%0b flag=%0b err=%0b exp 0/0/1/0",
               count_o, valid_o, flag, err_o);
    end
  endtask

  task automatic test_single_push();
    ready_i = 1'b0;
    wr_en = 1'b1; bg_i = 2'd1; ba_i = 2'd2; row_i = 16'h0A0B; idx_i = 6'h2A;
    data_i = 16'hBEEF; col_i = 10'h155; t_i = 1'b1;
    step();
    wr_en = 1'b0;
    tests_run++;
    if ({valid_o, ba_o, bg_o, hit_o, count_o} !== {1'b1, 2'd2, 2'd1, 1'b0, 4'd1}) begin
      tests_failed++;
      $display("FAIL t1_head got valid=%0b ba=%0d bg=%0d hit=%0b count=%0d exp 1/2/1/0/1",
               valid_o, ba_o, bg_o, hit_o, count_o);
    end
    tests_run++;
    if ({data_o, idx_o, row_o, col_o, t_o} !== {16'hBEEF, 6'h2A, 16'h0A0B, 10'h155, 1'b1}) begin
      tests_failed++;
      $display("FAIL t1_fields got data=%h idx=%h row=%h col=%h t=%0b", data_o, idx_o, row_o, col_o, t_o);
    end
    step();
    tests_run++;
    if ({valid_o, idx_o, row_o, count_o} !== {1'b1, 6'h2A, 16'h0A0B, 4'd1}) begin
      tests_failed++;
      $display("FAIL t1_stall_stable got valid=%0b idx=%h row=%h count=%0d", valid_o, idx_o, row_o, count_o);
    end
    ready_i = 1'b1;
    step();
    tests_run++;
    if ({valid_o, count_o, data_o, idx_o, row_o, col_o, t_o, ba_o, bg_o, hit_o} !== '0) begin
      tests_failed++;
      $display("FAIL t1_pop_empty got valid=%0b count=%0d data=%h idx=%h", valid_o, count_o, data_o, idx_o);
    end
    step();
    ready_i = 1'b0;
    tests_run++;
    if ({valid_o, count_o} !== {1'b0, 4'd0}) begin
      tests_failed++;
      $display("FAIL t1_ready_ignored got valid=%0b count=%0d exp 0/0", valid_o, count_o);
    end
  endtask

  task automatic test_row_hit();
    logic [2:0] exp_hits;
    exp_hits = 3'b010;
    ready_i = 1'b0;
    do_push(2'd1, 2'd1, 16'h0010, 6'd1, 1'b0);
    do_push(2'd1, 2'd1, 16'h0010, 6'd2, 1'b0);
    do_push(2'd1, 2'd1, 16'h0011, 6'd3, 1'b0);
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if ({idx_o, hit_o} !== {6'(k + 1), exp_hits[2-k]}) begin
        tests_failed++;
        $display("FAIL t2_hit%0d got idx=%0d hit=%0b exp idx=%0d hit=%0b",
                 k, idx_o, hit_o, k + 1, exp_hits[2-k]);
      end
      step();
    end
    ready_i = 1'b0;
  endtask

  task automatic test_flag_overflow();
    ready_i = 1'b0;
    for (int k = 1; k <= 6; k++) do_push(2'd0, 2'd0, 16'h0001, 6'(k), 1'b0);
    tests_run++;
    if ({count_o, flag, err_o} !== {4'd6, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL t3_six got count=%0d flag=%0b err=%0b exp 6/1/0", count_o, flag, err_o);
    end
    do_push(2'd0, 2'd0, 16'h0001, 6'd7, 1'b0);
    tests_run++;
    if ({count_o, flag} !== {4'd7, 1'b0}) begin
      tests_failed++;
      $display("FAIL t3_seven got count=%0d flag=%0b exp 7/0", count_o, flag);
    end
    do_push(2'd0, 2'd0, 16'h0001, 6'd8, 1'b0);
    tests_run++;
    if ({count_o, flag, err_o} !== {4'd8, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL t3_full got count=%0d flag=%0b err=%0b exp 8/0/0", count_o, flag, err_o);
    end
    do_push(2'd3, 2'd3, 16'h0200, 6'd40, 1'b0);
    tests_run++;
    if ({count_o, err_o, idx_o} !== {4'd8, 1'b1, 6'd1}) begin
      tests_failed++;
      $display("FAIL t3_drop got count=%0d err=%0b head_idx=%0d exp 8/1/1", count_o, err_o, idx_o);
    end
    ready_i = 1'b1;
    step();
    ready_i = 1'b0;
    // Bank 15 must still be closed: the dropped write may not have opened it.
    do_push(2'd3, 2'd3, 16'h0200, 6'd41, 1'b0);
    ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if ({idx_o, hit_o} !== ((k < 7) ? {6'(k + 2), 1'b1} : {6'd41, 1'b0})) begin
        tests_failed++;
        $display("FAIL t3_drain%0d got idx=%0d hit=%0b", k, idx_o, hit_o);
      end
      step();
    end
    ready_i = 1'b0;
    tests_run++;
    if ({count_o, err_o} !== {4'd0, 1'b1}) begin
      tests_failed++;
      $display("FAIL t3_err_sticky got count=%0d err=%0b exp 0/1", count_o, err_o);
    end
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    ready_i = 1'b0;
    for (int k = 0; k < 8; k++) do_push(2'd0, 2'd1, 16'h0100, 6'(k), 1'b0);
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (idx_o !== 6'(k)) begin
        tests_failed++;
        $display("FAIL t4_head%0d got idx=%0d exp %0d", k, idx_o, k);
      end
      ready_i = 1'b1;
      do_push(2'd0, 2'd1, 16'h0100, 6'(k + 8), 1'b0);
      ready_i = 1'b0;
      tests_run++;
      if ({count_o, err_o, flag} !== {4'd8, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL t4_full_pp%0d got count=%0d err=%0b flag=%0b exp 8/0/0", k, count_o, err_o, flag);
      end
    end
    ready_i = 1'b1;
    for (int k = 4; k < 12; k++) begin
      tests_run++;
      if (idx_o !== 6'(k)) begin
        tests_failed++;
        $display("FAIL t4_order%0d got idx=%0d exp %0d", k, idx_o, k);
      end
      step();
    end
    ready_i = 1'b0;
    tests_run++;
    if ({count_o, valid_o, flag} !== {4'd0, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL t4_drained got count=%0d valid=%0b flag=%0b exp 0/0/1", count_o, valid_o, flag);
    end
  endtask

  task automatic test_pre_all();
    logic [3:0] exp_hits;
    exp_hits = 4'b0010;
    ready_i = 1'b0;
    do_push(2'd0, 2'd3, 16'h0077, 6'd20, 1'b0);
    do_push(2'd0, 2'd3, 16'h0077, 6'd21, 1'b1);
    do_push(2'd0, 2'd3, 16'h0077, 6'd22, 1'b0);
    do_push(2'd0, 2'd3, 16'h0078, 6'd23, 1'b0);
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if ({idx_o, hit_o} !== {6'(k + 20), exp_hits[3-k]}) begin
        tests_failed++;
        $display("FAIL t5_hit%0d got idx=%0d hit=%0b exp idx=%0d hit=%0b",
                 k, idx_o, hit_o, k + 20, exp_hits[3-k]);
      end
      step();
    end
    ready_i = 1'b0;
  endtask

  task automatic test_mid_reset();
    ready_i = 1'b0;
    for (int k = 0; k < 5; k++) do_push(2'd2, 2'd0, 16'h0300, 6'(k + 30), 1'b0);
    tests_run++;
    if ({count_o, valid_o} !== {4'd5, 1'b1}) begin
      tests_failed++;
      $display("FAIL t6_pre got count=%0d valid=%0b exp 5/1", count_o, valid_o);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests_run++;
    if ({count_o, valid_o, flag, err_o} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL t6_reset got count=%0d valid=%0b flag=%0b err=%0b exp 0/0/1/0",
               count_o, valid_o, flag, err_o);
    end
    tests_run++;
    if ({data_o, idx_o, row_o, col_o, t_o, ba_o, bg_o, hit_o} !== '0) begin
      tests_failed++;
      $display("FAIL t6_fields got data=%h idx=%h row=%h col=%h", data_o, idx_o, row_o, col_o);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; data_i = '0; idx_i = '0; row_i = '0; col_i = '0;
    t_i = 1'b0; ba_i = '0; bg_i = '0; pre_all = 1'b0; ready_i = 1'b0;
    test_reset();
    test_single_push();
    test_row_hit();
    test_flag_overflow();
    test_back_to_back();
    test_pre_all();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
